serial_frame_rx: RTL

Serial-to-parallel frame receiver on the `sclk` domain, sitting directly downstream of the 8-bit LSB-first serializer. It samples one bit per `sclk` edge while the frame enable is high and assembles a two-word frame: an address word, then a data word. On a complete frame it presents both words with a one-cycle valid pulse; aborted frames are discarded and flagged.

---
 rtl/psec_serial_pkg.sv | 21 ++
 rtl/serial_shift_in.sv | 43 ++++
 rtl/serial_frame_rx.sv | 99 +++++++++
 3 files changed

// File: rtl/psec_serial_pkg.sv
// ---------------------------------------------------------------------------
// psec_serial_pkg : shared types and constants for the serial frame receiver
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package psec_serial_pkg;

  localparam int WORD_W_DEFAULT = 8;
  localparam int FRAME_WORDS    = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    HOLD = 2'd3
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/serial_shift_in.sv
// ---------------------------------------------------------------------------
// serial_shift_in : LSB-first shift register with word bit counter
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module serial_shift_in
  import psec_serial_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEFAULT
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              shift_en,
  input  logic              clr,
  input  logic              sin,
  output logic [WORD_W-1:0] word,
  output logic              word_done
);

  localparam int                CNT_W    = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WORD_W - 1);

  logic [WORD_W-1:0] sr;
  logic [CNT_W-1:0]  cnt;

  // word includes the bit being accepted this edge, so it is complete with word_done
  assign word      = {sin, sr[WORD_W-1:1]};
  assign word_done = shift_en && (cnt == CNT_LAST);

  always_ff @(posedge sclk) begin
    if (rst || clr) begin
      sr  <= '0;
      cnt <= '0;
    end else if (shift_en) begin
      sr  <= word;
      cnt <= word_done ? '0 : cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/serial_frame_rx.sv
// ---------------------------------------------------------------------------
// serial_frame_rx : receives address+data serial frames, flags aborted frames
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module serial_frame_rx
  import psec_serial_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEFAULT
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              sin,
  input  logic              sin_en,
  output logic [WORD_W-1:0] addr_out,
  output logic [WORD_W-1:0] data_out,
  output logic              frame_valid,
  output logic              frame_err,
  output logic              busy
);

  rx_state_t         state;
  rx_state_t         state_nx;
  logic              shift_en;
  logic              clr;
  logic              word_done;
  logic [WORD_W-1:0] word;
  logic [WORD_W-1:0] addr_hold;
  logic              load_addr;
  logic              load_frame;
  logic              abort;

  serial_shift_in #(
    .WORD_W (WORD_W)
  ) u_shift (
    .sclk      (sclk),
    .rst       (rst),
    .shift_en  (shift_en),
    .clr       (clr),
    .sin       (sin),
    .word      (word),
    .word_done (word_done)
  );

  always_ff @(posedge sclk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (sin_en) state_nx = ADDR;
      ADDR: begin
        if (!sin_en)        state_nx = IDLE;
        else if (word_done) state_nx = DATA;
      end
      DATA: begin
        if (!sin_en)        state_nx = IDLE;
        else if (word_done) state_nx = HOLD;
      end
      HOLD: if (!sin_en) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Bits arriving in HOLD are dropped; any low enable edge restarts the counter
  always_comb begin
    shift_en   = sin_en && (state != HOLD);
    clr        = !sin_en;
    load_addr  = (state == ADDR) && word_done;
    load_frame = (state == DATA) && word_done;
    abort      = !sin_en && ((state == ADDR) || (state == DATA));
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      addr_hold   <= '0;
      addr_out    <= '0;
      data_out    <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      frame_valid <= load_frame;
      frame_err   <= abort;
      busy        <= (state_nx == ADDR) || (state_nx == DATA);
      if (load_addr) addr_hold <= word;
      if (load_frame) begin
        addr_out <= addr_hold;
        data_out <= word;
      end
    end
  end

endmodule

`default_nettype wire
